mod_hk_copier: RTL
==================

MOD_HK_COPIER -- requirements
Module: MOD_HK_COPIER

Interface
REQ-001 Parameter H_WORDS, default 8, number of 32-bit H constants, at ROM bytes 0..31.
REQ-002 Parameter K_WORDS, default 64, number of 32-bit K constants, at ROM bytes 32..287.
REQ-003 Parameter K_BASE, default 64, RAM word address of K[0]; H[0] is at RAM word 0.
REQ-004 CLK  in  1  single clock; all state changes on the rising edge.
REQ-005 RST  in  1  asynchronous, active-high reset.
REQ-006 COPY_ROM  in  1  level request; copy runs while high.
REQ-007 COPY_ROM_COMPLETE  out  1  copy finished; high until COPY_ROM falls.
REQ-008 ROM_ADDR  out  9  byte address to the byte-wide synchronous ROM.
REQ-009 ROM_DATA  in  8  ROM byte, valid one cycle after ROM_ADDR.
REQ-010 RAM_ADDR  out  7  word address to the four byte banks.
REQ-011 RAM_WDATA  out  32  write word; [31:24] to bank_1 ... [7:0] to bank_4.
REQ-012 RAM_WE  out  1  one-cycle word write strobe, all four banks.
REQ-013 COPY_ERR  out  1  readback mismatch flag; exists only with MOD_HK_COPY_VERIFY_EN.
REQ-014 RAM_RDATA  in  32  readback word, valid one cycle after RAM_ADDR; exists only with MOD_HK_COPY_VERIFY_EN.

Function
REQ-015 States: IDLE, FETCH, WRITE, DONE; plus VREAD, VCHECK with MOD_HK_COPY_VERIFY_EN.
REQ-016 IDLE -> FETCH on the edge sampling COPY_ROM=1; byte counter cleared, ROM_ADDR=0.
REQ-017 FETCH: ROM_ADDR increments each cycle; each ROM_DATA byte is shifted into a 32-bit assembler, first byte becomes [31:24] (big-endian).
REQ-018 After the 4th byte of a word is captured, WRITE asserts RAM_WE for exactly one cycle with the assembled word; fetching continues without stall.
REQ-019 Word index w < H_WORDS writes RAM_ADDR=w; otherwise RAM_ADDR=K_BASE+(w-H_WORDS).
REQ-020 Exactly H_WORDS+K_WORDS writes per copy, each RAM address written once, in ascending word order; no writes to RAM words 8..63.
REQ-021 ROM_ADDR stops at 287; no address beyond the last byte is issued.
REQ-022 After the last write -> DONE (or VREAD); COPY_ROM_COMPLETE rises the cycle after the final write, within 292 cycles of start.
REQ-023 DONE holds COPY_ROM_COMPLETE=1 while COPY_ROM=1; COPY_ROM=0 -> IDLE, COPY_ROM_COMPLETE=0 next cycle.
REQ-024 COPY_ROM falling in FETCH/WRITE/VREAD/VCHECK aborts: -> IDLE next edge, RAM_WE=0, no COMPLETE; a later request restarts from byte 0.
REQ-025 COPY_ROM held high after DONE does not restart a copy; a new copy requires a low-then-high request.

Reset
REQ-026 RST=1 forces IDLE immediately: COPY_ROM_COMPLETE=0, RAM_WE=0, ROM_ADDR=0, RAM_ADDR=0, RAM_WDATA=0, COPY_ERR=0, counters and assembler cleared.
REQ-027 Reset mid-copy leaves RAM contents undefined; first request after RST release performs a full copy.

Configuration
REQ-028 Macro MOD_HK_COPY_VERIFY_EN: when defined, after the last write the block reads all 72 words back (VREAD issues address, VCHECK compares RAM_RDATA with the 32-bit wrapping sum of written words), sets sticky COPY_ERR on sum mismatch, then enters DONE; completion latency grows by 2*72 cycles max.
REQ-029 Without the macro: no VREAD/VCHECK, no COPY_ERR/RAM_RDATA ports, no checksum logic.

Structure
REQ-030 Shared package holds state encoding, H_WORDS/K_WORDS/K_BASE defaults, ROM byte total (288), RAM address width (7).
REQ-031 One sub-module MOD_BYTE_ASSEMBLER (4-byte shift assembler with word-ready pulse); everything else in MOD_HK_COPIER.

Verification
REQ-032 ROM loaded with SHA-256 H/K; COPY_ROM=1 -> RAM word 0 = 6a09e667, word 7 = 5be0cd19, word 64 = 428a2f98, word 127 = c67178f2, COMPLETE within 292 cycles.
REQ-033 Count RAM_WE pulses during one copy -> exactly 72, addresses 0..7 then 64..127, never 8..63.
REQ-034 Drop COPY_ROM after 100 cycles -> IDLE, no COMPLETE; reassert -> full copy, same RAM contents as REQ-032.
REQ-035 Assert RST during word 30 write -> all outputs zero same cycle; after release and request, full 72-word copy.
REQ-036 Hold COPY_ROM high 500 cycles after COMPLETE -> COMPLETE stays 1, zero further RAM_WE.
REQ-037 With MOD_HK_COPY_VERIFY_EN, corrupt readback of word 64 to 00000000 -> COPY_ERR=1 at COMPLETE; clean run -> COPY_ERR=0.

Source files
------------

// File: rtl/mod_hk_copier_pkg.sv
// -----------------------------------------------------------------------------
// mod_hk_copier_pkg
// Shared definitions for the SHA-256 H/K constant copier.
//   - Default geometry: 8 H words and 64 K words. H lands at RAM word 0 and
//     K lands at RAM word 64.
//   - ROM byte total and the derived ROM / RAM address widths.
//   - FSM state encoding. VREAD/VCHECK exist only when MOD_HK_COPY_VERIFY_EN
//     is defined.
// -----------------------------------------------------------------------------
package mod_hk_copier_pkg;

  localparam int H_WORDS_DEF = 8;
  localparam int K_WORDS_DEF = 64;
  localparam int K_BASE_DEF  = 64;

  // 72 big-endian words of 4 bytes each.
  localparam int ROM_BYTES = 4 * (H_WORDS_DEF + K_WORDS_DEF);
  localparam int ROM_AW    = $clog2(ROM_BYTES);
  localparam int RAM_AW    = 7;

`ifdef MOD_HK_COPY_VERIFY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WRITE  = 3'd2,
    ST_DONE   = 3'd3,
    ST_VREAD  = 3'd4,
    ST_VCHECK = 3'd5
  } copier_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } copier_state_t;
`endif

endpackage

// File: rtl/mod_hk_copier_byte_assembler.sv
// -----------------------------------------------------------------------------
// mod_byte_assembler
// Packs a stream of bytes into 32-bit words. The first byte becomes [31:24].
// The fourth byte is not registered. Instead, word is combinationally
// {three held bytes, byte_in}, and word_ready pulses in the same cycle the
// fourth byte is presented. This lets the consumer register the finished word
// on that edge.
// Ports:
//   CLK, RST    clock, asynchronous active-high reset
//   clear       synchronous clear of held bytes and byte count
//   byte_valid  byte_in carries a stream byte this cycle
//   byte_in     stream byte
//   word        assembled word, meaningful while word_ready is high
//   word_ready  one-cycle pulse when the fourth byte of a word is present
// -----------------------------------------------------------------------------
module mod_byte_assembler (
  input  logic        CLK,
  input  logic        RST,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [23:0] shift_reg;
  logic [1:0]  cnt_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (clear) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (byte_valid) begin
      shift_reg <= {shift_reg[15:0], byte_in};
      // Wraps to 0 after the fourth byte, ready for the next word.
      cnt_reg   <= cnt_reg + 2'd1;
    end
  end

  assign word       = {shift_reg, byte_in};
  assign word_ready = byte_valid && (cnt_reg == 2'd3);

endmodule

// File: rtl/mod_hk_copier.sv
// -----------------------------------------------------------------------------
// mod_hk_copier
// Copies the SHA-256 H and K constants from a byte-wide synchronous ROM into
// a word RAM built from four byte banks. H[w] goes to RAM word w.
// K[j] goes to RAM word K_BASE + j.
// Optional feature macro: MOD_HK_COPY_VERIFY_EN. When it is defined, all words
// are read back after the copy, and their wrapping 32-bit sum is compared
// against the sum of the words that were written.
// Ports:
//   CLK                clock, rising edge
//   RST                asynchronous active-high reset
//   COPY_ROM           level request; the copy runs while it is high
//   COPY_ROM_COMPLETE  high in DONE until COPY_ROM falls
//   ROM_ADDR           ROM byte address; ROM_DATA is valid one cycle later
//   ROM_DATA           ROM byte
//   RAM_ADDR           RAM word address
//   RAM_WDATA          RAM write word; [31:24] goes to bank_1, [7:0] to bank_4
//   RAM_WE             one-cycle write strobe to all four banks
//   COPY_ERR           (verify build only) sticky readback-sum mismatch
//   RAM_RDATA          (verify build only) readback word, one cycle after
//                      RAM_ADDR
// -----------------------------------------------------------------------------
module mod_hk_copier
  import mod_hk_copier_pkg::*;
#(
  parameter int H_WORDS = H_WORDS_DEF,
  parameter int K_WORDS = K_WORDS_DEF,
  parameter int K_BASE  = K_BASE_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              COPY_ROM,
  output logic              COPY_ROM_COMPLETE,
  output logic [ROM_AW-1:0] ROM_ADDR,
  input  logic [7:0]        ROM_DATA,
  output logic [RAM_AW-1:0] RAM_ADDR,
  output logic [31:0]       RAM_WDATA,
  output logic              RAM_WE
`ifdef MOD_HK_COPY_VERIFY_EN
  ,
  output logic              COPY_ERR,
  input  logic [31:0]       RAM_RDATA
`endif
);

  localparam int                TOTAL_WORDS = H_WORDS + K_WORDS;
  localparam logic [ROM_AW-1:0] ROM_LAST    = ROM_AW'(4 * TOTAL_WORDS - 1);
  localparam logic [RAM_AW-1:0] LAST_WORD   = RAM_AW'(TOTAL_WORDS - 1);

  // Word index to RAM word address. The H block is packed at 0.
  // The K block starts at K_BASE.
  function automatic logic [RAM_AW-1:0] word_to_ram(input logic [RAM_AW-1:0] w);
    if (w < RAM_AW'(H_WORDS))
      return w;
    return RAM_AW'(K_BASE) + (w - RAM_AW'(H_WORDS));
  endfunction

  copier_state_t     state_reg, state_next;
  logic [ROM_AW-1:0] rom_addr_reg;
  logic              issue_done_reg;   // last ROM byte address already issued
  logic              byte_valid_reg;   // ROM_DATA holds a requested byte
  logic [RAM_AW-1:0] word_idx_reg;
  logic              last_word_reg;    // the pending WRITE is the final word
  logic [RAM_AW-1:0] ram_addr_reg;
  logic [31:0]       ram_wdata_reg;

  logic              fetching;
  logic              start;
  logic [31:0]       asm_word;
  logic              asm_ready;

`ifdef MOD_HK_COPY_VERIFY_EN
  logic [31:0]       wr_sum_reg;
  logic [31:0]       rd_sum_reg;
  logic [31:0]       rd_sum_next;
  logic [RAM_AW-1:0] vidx_reg;
  logic              copy_err_reg;
`endif

  // ROM reads keep going through WRITE cycles, so the byte stream never
  // stalls.
  assign fetching = (state_reg == ST_FETCH) || (state_reg == ST_WRITE);
  assign start    = (state_reg == ST_IDLE) && COPY_ROM;

  mod_byte_assembler u_assembler (
    .CLK        (CLK),
    .RST        (RST),
    .clear      (~fetching),
    .byte_valid (byte_valid_reg & fetching),
    .byte_in    (ROM_DATA),
    .word       (asm_word),
    .word_ready (asm_ready)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next        = state_reg;
    RAM_WE            = 1'b0;
    COPY_ROM_COMPLETE = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (COPY_ROM)
          state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (!COPY_ROM)
          state_next = ST_IDLE;
        else if (asm_ready)
          state_next = ST_WRITE;
      end
      ST_WRITE: begin
        RAM_WE = 1'b1;
        if (!COPY_ROM)
          state_next = ST_IDLE;
        else if (last_word_reg)
`ifdef MOD_HK_COPY_VERIFY_EN
          state_next = ST_VREAD;
`else
          state_next = ST_DONE;
`endif
        else
          state_next = ST_FETCH;
      end
      ST_DONE: begin
        COPY_ROM_COMPLETE = 1'b1;
        if (!COPY_ROM)
          state_next = ST_IDLE;
      end
`ifdef MOD_HK_COPY_VERIFY_EN
      ST_VREAD: begin
        if (!COPY_ROM)
          state_next = ST_IDLE;
        else
          state_next = ST_VCHECK;
      end
      ST_VCHECK: begin
        if (!COPY_ROM)
          state_next = ST_IDLE;
        else if (vidx_reg == LAST_WORD)
          state_next = ST_DONE;
        else
          state_next = ST_VREAD;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
`ifdef MOD_HK_COPY_VERIFY_EN
  assign rd_sum_next = rd_sum_reg + RAM_RDATA;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rom_addr_reg   <= '0;
      issue_done_reg <= 1'b0;
      byte_valid_reg <= 1'b0;
      word_idx_reg   <= '0;
      last_word_reg  <= 1'b0;
      ram_addr_reg   <= '0;
      ram_wdata_reg  <= '0;
`ifdef MOD_HK_COPY_VERIFY_EN
      wr_sum_reg     <= '0;
      rd_sum_reg     <= '0;
      vidx_reg       <= '0;
      copy_err_reg   <= 1'b0;
`endif
    end else if (start) begin
      // Every new request restarts from byte 0, including after an abort.
      rom_addr_reg   <= '0;
      issue_done_reg <= 1'b0;
      byte_valid_reg <= 1'b0;
      word_idx_reg   <= '0;
      last_word_reg  <= 1'b0;
`ifdef MOD_HK_COPY_VERIFY_EN
      // The error flag describes the most recent copy.
      wr_sum_reg     <= '0;
      copy_err_reg   <= 1'b0;
`endif
    end else if (fetching) begin
      // The address presented this cycle is sampled by the ROM at this edge.
      byte_valid_reg <= ~issue_done_reg;
      if (!issue_done_reg) begin
        if (rom_addr_reg == ROM_LAST)
          issue_done_reg <= 1'b1;          // hold at the last byte
        else
          rom_addr_reg <= rom_addr_reg + 1'b1;
      end
      if (asm_ready) begin
        ram_addr_reg  <= word_to_ram(word_idx_reg);
        ram_wdata_reg <= asm_word;
        word_idx_reg  <= word_idx_reg + 1'b1;
        last_word_reg <= (word_idx_reg == LAST_WORD);
`ifdef MOD_HK_COPY_VERIFY_EN
        wr_sum_reg    <= wr_sum_reg + asm_word;
`endif
      end
`ifdef MOD_HK_COPY_VERIFY_EN
      // Leaving the final WRITE: present the first readback address.
      if ((state_reg == ST_WRITE) && last_word_reg) begin
        ram_addr_reg <= word_to_ram('0);
        vidx_reg     <= '0;
        rd_sum_reg   <= '0;
      end
`endif
    end else begin
      byte_valid_reg <= 1'b0;
`ifdef MOD_HK_COPY_VERIFY_EN
      if (state_reg == ST_VCHECK) begin
        rd_sum_reg <= rd_sum_next;
        if (vidx_reg == LAST_WORD) begin
          if (rd_sum_next != wr_sum_reg)
            copy_err_reg <= 1'b1;
        end else begin
          vidx_reg     <= vidx_reg + 1'b1;
          ram_addr_reg <= word_to_ram(vidx_reg + 1'b1);
        end
      end
`endif
    end
  end

  assign ROM_ADDR  = rom_addr_reg;
  assign RAM_ADDR  = ram_addr_reg;
  assign RAM_WDATA = ram_wdata_reg;
`ifdef MOD_HK_COPY_VERIFY_EN
  assign COPY_ERR  = copy_err_reg;
`endif

endmodule
